// File: rtl/div_seq.sv
// ---------------------------------------------------------------------------
// div_seq : iterative restoring divider for EX-stage DIV / DIVU.
//
// EX raises start_i and holds it (stalling) until ready_o is set. The divider
// performs one restoring step per clock on operand magnitudes, then applies
// the sign fixup. The result is {remainder, quotient} for HI/LO.
//
// Ports
//   clk           in   rising-edge clock
//   resetn        in   asynchronous active-low reset
//   signed_div_i  in   1 = DIV (signed), 0 = DIVU
//   opdata1_i     in   dividend (WIDTH)
//   opdata2_i     in   divisor  (WIDTH)
//   start_i       in   request, held high until ready_o
//   annul_i       in   abort the in-flight divide
//   result_o      out  {remainder, quotient} (2*WIDTH), zero unless ready_o
//   ready_o       out  result valid (registered)
//   byzero_o      out  divisor was zero (only with DIV_BYZERO_FLAG_EN)
//
// Configuration macro: DIV_BYZERO_FLAG_EN adds the byzero_o port.
// ---------------------------------------------------------------------------
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
`ifdef DIV_BYZERO_FLAG_EN
    ,
    output logic               byzero_o
`endif
);

    typedef enum logic [1:0] {
        S_FREE   = 2'b00,
        S_BYZERO = 2'b01,
        S_ON     = 2'b10,
        S_END    = 2'b11
    } state_t;

    localparam int              CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   result_q;
    logic                 ready_q;
`ifdef DIV_BYZERO_FLAG_EN
    logic                 byzero_q;
`endif

    logic [WIDTH-1:0]     rem_q, quo_q, dvsr_q;
    logic [WIDTH-1:0]     rem_d, quo_d;
    logic                 neg_quo_q, neg_rem_q;
    logic [WIDTH:0]       rem_sh, trial;
    logic                 take;
    logic                 accept;

    // Unsigned magnitude of an operand; the most negative value maps to
    // itself, which is the correct magnitude when read as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                   input logic is_signed);
        if (is_signed && (v < 0))
            return -v;
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                    input logic neg);
        return neg ? ('0 - v) : v;
    endfunction

    assign accept = start_i && !annul_i;

    // One restoring step. The shifted remainder needs WIDTH+1 bits because the
    // divisor may use the full unsigned range. A non-negative trial is always
    // below the divisor, so its top bit is a pure borrow flag.
    always_comb begin
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        trial  = rem_sh - {1'b0, dvsr_q};
        take   = ~trial[WIDTH];
        rem_d  = take ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_d  = {quo_q[WIDTH-2:0], take};
    end

    // Datapath: operands are latched once at acceptance, later input changes
    // are ignored. No reset needed; contents are meaningless outside ON.
    always_ff @(posedge clk) begin
        if (state_q == S_FREE && accept) begin
            rem_q     <= '0;
            quo_q     <= magnitude(opdata1_i, signed_div_i);
            dvsr_q    <= magnitude(opdata2_i, signed_div_i);
            neg_quo_q <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_rem_q <= signed_div_i && opdata1_i[WIDTH-1];
        end else if (state_q == S_ON && cnt_q != LAST) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_FREE;
            cnt_q    <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
`ifdef DIV_BYZERO_FLAG_EN
            byzero_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_FREE: begin
                    // annul_i wins over a simultaneous start_i
                    if (accept) begin
                        if (opdata2_i == '0) begin
                            state_q <= S_BYZERO;
                        end else begin
                            state_q <= S_ON;
                            cnt_q   <= '0;
                        end
                    end
                end
                S_BYZERO: begin
                    state_q  <= S_END;
                    result_q <= '0;
                    ready_q  <= 1'b1;
`ifdef DIV_BYZERO_FLAG_EN
                    byzero_q <= 1'b1;
`endif
                end
                S_ON: begin
                    if (!accept) begin
                        state_q <= S_FREE;
                    end else if (cnt_q == LAST) begin
                        state_q  <= S_END;
                        ready_q  <= 1'b1;
                        result_q <= {apply_sign(rem_q, neg_rem_q),
                                     apply_sign(quo_q, neg_quo_q)};
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_END: begin
                    if (!accept) begin
                        state_q  <= S_FREE;
                        ready_q  <= 1'b0;
                        result_q <= '0;
`ifdef DIV_BYZERO_FLAG_EN
                        byzero_q <= 1'b0;
`endif
                    end
                end
                default: state_q <= S_FREE;
            endcase
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
`ifdef DIV_BYZERO_FLAG_EN
    assign byzero_o = byzero_q;
`endif

endmodule
